qblock_room_tracker: RTL and testbench

- Per-room question-block state engine; one instance per room (room 1, room 3). Feeds is_question / empty / address per pixel to the downstream question level-select mux.
- Holds the used bitmap and accepts head-hit events from the Mario collision logic.
- Runs the bump animation, then requests a coin spawn through a req/ack handshake.
- Produces the registered per-pixel sprite hit, empty flag and 9-bit sprite ROM address.

---
 rtl/qblock_room_tracker.sv | 183 ++++++++++++++++++
 tb/tb_qblock_room_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/qblock_room_tracker.sv
// rtl/qblock_room_tracker.sv - per-room question-block state, bump/coin sequencing and sprite render
// Tracks used blocks, animates a bump on head-hit, then hands a coin spawn off via req/ack.
module qblock_room_tracker #(
  parameter int                       NUM_BLOCKS   = 4,
  parameter logic [NUM_BLOCKS*10-1:0] BLK_X        = '0,
  parameter logic [NUM_BLOCKS*10-1:0] BLK_Y        = '0,
  parameter int                       BUMP_FRAMES  = 8,
  parameter int                       FLASH_PERIOD = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       room_active,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       hit_valid,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       hit_ready,
  output logic       coin_req,
  input  logic       coin_ack,
  output logic [9:0] coin_x,
  output logic [9:0] coin_y,
  output logic       is_question,
  output logic       empty_question,
  output logic [8:0] question_address
);

  localparam logic [4:0] BUMP_LEN   = 5'(BUMP_FRAMES);
  localparam logic [4:0] BUMP_LAST  = 5'(BUMP_FRAMES - 1);
  localparam logic [5:0] FLASH_LAST = 6'(FLASH_PERIOD - 1);
  localparam logic [5:0] FLASH_HALF = 6'(FLASH_PERIOD / 2);

  typedef enum logic [1:0] {IDLE, BUMP, COIN} state_t;

  state_t      state, state_next;
  logic [7:0]  used;
  logic [2:0]  idx;
  logic [4:0]  bump_cnt;
  logic [5:0]  flash_cnt;
  logic        phase;
  logic        go_coin;
  logic        start_bump;

  assign phase = (flash_cnt >= FLASH_HALF);

  // Gated by Reset so every output reads 0 while reset is held.
  assign hit_ready = Reset && room_active && (state == IDLE);

  logic        hit_match;
  logic [2:0]  hit_idx;
  logic [10:0] hbx, hby;

  always_comb begin
    hit_match = 1'b0;
    hit_idx   = '0;
    hbx       = '0;
    hby       = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      hbx = {1'b0, BLK_X[10*i +: 10]};
      hby = {1'b0, BLK_Y[10*i +: 10]};
      if ({1'b0, hit_x} >= hbx && {1'b0, hit_x} <= hbx + 11'd15 &&
          {1'b0, hit_y} >= hby && {1'b0, hit_y} <= hby + 11'd15) begin
        hit_match = 1'b1;
        hit_idx   = 3'(i);
      end
    end
  end

  assign start_bump = hit_valid && hit_ready && hit_match && !used[hit_idx];

  logic [9:0] sel_x, sel_y;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (idx == 3'(i)) begin
        sel_x = BLK_X[10*i +: 10];
        sel_y = BLK_Y[10*i +: 10];
      end
    end
  end

  // Triangle-shaped lift: rises to the midpoint frame then falls back.
  logic [4:0] bump_rem, bump_min;
  logic [5:0] bump_dbl;
  logic [3:0] off;

  always_comb begin
    bump_rem = BUMP_LEN - bump_cnt;
    bump_min = (bump_cnt < bump_rem) ? bump_cnt : bump_rem;
    bump_dbl = {bump_min, 1'b0};
    off      = (bump_dbl > 6'd15) ? 4'd15 : bump_dbl[3:0];
  end

  always_comb begin
    state_next = state;
    go_coin    = 1'b0;
    case (state)
      IDLE: if (start_bump) state_next = BUMP;
      BUMP: begin
        if (!room_active) begin
          state_next = IDLE;
        end else if (frame_tick && bump_cnt == BUMP_LAST) begin
          state_next = COIN;
          go_coin    = 1'b1;
        end
      end
      COIN: if (!room_active || (coin_ack && coin_req)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic        r_hit, r_used;
  logic [3:0]  r_dx, r_dy, r_off;
  logic [10:0] rdx, rdy;

  always_comb begin
    r_hit  = 1'b0;
    r_used = 1'b0;
    r_dx   = '0;
    r_dy   = '0;
    r_off  = '0;
    rdx    = '0;
    rdy    = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      r_off = (state == BUMP && idx == 3'(i)) ? off : 4'd0;
      rdx   = {1'b0, DrawX} - {1'b0, BLK_X[10*i +: 10]};
      rdy   = {1'b0, DrawY} - {1'b0, BLK_Y[10*i +: 10]} + {7'd0, r_off};
      if (!rdx[10] && rdx[9:4] == 6'd0 && !rdy[10] && rdy[9:4] == 6'd0) begin
        r_hit  = 1'b1;
        r_used = used[3'(i)];
        r_dx   = rdx[3:0];
        r_dy   = rdy[3:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      used             <= '0;
      idx              <= '0;
      bump_cnt         <= '0;
      flash_cnt        <= '0;
      coin_req         <= 1'b0;
      coin_x           <= '0;
      coin_y           <= '0;
      is_question      <= 1'b0;
      empty_question   <= 1'b0;
      question_address <= '0;
    end else begin
      if (start_bump) begin
        used[hit_idx] <= 1'b1;
        idx           <= hit_idx;
        bump_cnt      <= '0;
      end else if (state == BUMP) begin
        if (state_next != BUMP) bump_cnt <= '0;
        else if (frame_tick)    bump_cnt <= bump_cnt + 5'd1;
      end

      if (go_coin) begin
        coin_req <= 1'b1;
        coin_x   <= sel_x;
        coin_y   <= (sel_y >= 10'd16) ? sel_y - 10'd16 : 10'd0;
      end else if (state_next != COIN) begin
        coin_req <= 1'b0;
      end

      if (frame_tick) flash_cnt <= (flash_cnt == FLASH_LAST) ? 6'd0 : flash_cnt + 6'd1;

      is_question      <= room_active && r_hit;
      empty_question   <= room_active && r_hit && r_used;
      question_address <= (room_active && r_hit) ? {phase & ~r_used, r_dy, r_dx} : 9'd0;
    end
  end

endmodule

// File: tb/tb_qblock_room_tracker.sv
// tb/tb_qblock_room_tracker.sv - scoreboard bench for qblock_room_tracker
module tb_qblock_room_tracker;

  localparam logic [39:0] BX = {10'd8,  10'd300, 10'd168, 10'd160};
  localparam logic [39:0] BY = {10'd10, 10'd200, 10'd124, 10'd120};

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick, room_active;
  logic [9:0] DrawX, DrawY;
  logic       hit_valid;
  logic [9:0] hit_x, hit_y;
  logic       hit_ready, coin_req, coin_ack;
  logic [9:0] coin_x, coin_y;
  logic       is_question, empty_question;
  logic [8:0] question_address;

  qblock_room_tracker #(
    .NUM_BLOCKS(4), .BLK_X(BX), .BLK_Y(BY), .BUMP_FRAMES(8), .FLASH_PERIOD(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .room_active(room_active),
    .DrawX(DrawX), .DrawY(DrawY), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ready(hit_ready), .coin_req(coin_req), .coin_ack(coin_ack),
    .coin_x(coin_x), .coin_y(coin_y), .is_question(is_question),
    .empty_question(empty_question), .question_address(question_address)
  );

  always #5 Clk = ~Clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_ticks = 0;
  logic [10:0] exp_q[$];
  int          off_tab[8] = '{0, 2, 4, 6, 8, 6, 4, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_ticks++;
  endtask

  function automatic logic phase_exp();
    return (m_ticks % 16) >= 8;
  endfunction

  // Expected render word {is_question, empty, address} is queued as the pixel is driven.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic q, input logic e, input logic ph, input logic [7:0] dydx);
    exp_q.push_back({q, e, ph, dydx});
    DrawX = x;
    DrawY = y;
    step();
    check(tag, {21'd0, is_question, empty_question, question_address}, {21'd0, exp_q.pop_front()});
  endtask

  task automatic do_hit(input logic [9:0] x, input logic [9:0] y);
    hit_valid = 1'b1;
    hit_x = x;
    hit_y = y;
    step();
    hit_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; frame_tick = 1'b0; room_active = 1'b1; coin_ack = 1'b0;
    hit_valid = 1'b0; hit_x = '0; hit_y = '0; DrawX = 10'd165; DrawY = 10'd123;
    step(); step();
    check("rst_hit_ready", {31'd0, hit_ready}, 0);
    check("rst_render", {21'd0, is_question, empty_question, question_address}, 0);
    check("rst_coin", {11'd0, coin_req, coin_x, coin_y}, 0);
    Reset = 1'b1;
    step();
    check("rel_hit_ready", {31'd0, hit_ready}, 1);

    probe("render_b0", 10'd165, 10'd123, 1'b1, 1'b0, phase_exp(), 8'h35);
    probe("render_miss", 10'd176, 10'd123, 1'b0, 1'b0, 1'b0, 8'h00);

    // First hit lands in the block 0 / block 1 overlap; block 0 must win.
    do_hit(10'd170, 10'd130);
    check("bump_hit_ready", {31'd0, hit_ready}, 0);
    probe("b1_untouched", 10'd180, 10'd137, 1'b1, 1'b0, phase_exp(), 8'hDC);
    for (int k = 0; k < 8; k++) begin
      check("bump_no_coin", {31'd0, coin_req}, 0);
      probe($sformatf("bump_off%0d", k), 10'd160, 10'd120, 1'b1, 1'b1, 1'b0,
            {4'(off_tab[k]), 4'd0});
      pulse_tick();
    end
    check("coin_req", {31'd0, coin_req}, 1);
    check("coin_x", {22'd0, coin_x}, 160);
    check("coin_y", {22'd0, coin_y}, 104);

    for (int c = 0; c < 20; c++) step();
    check("coin_hold", {31'd0, coin_req}, 1);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    check("ack_clear", {31'd0, coin_req}, 0);
    check("ack_ready", {31'd0, hit_ready}, 1);

    do_hit(10'd165, 10'd125);
    check("rehit_ready", {31'd0, hit_ready}, 1);
    probe("rehit_used", 10'd165, 10'd123, 1'b1, 1'b1, 1'b0, 8'h35);
    probe("b2_flash", 10'd305, 10'd205, 1'b1, 1'b0, phase_exp(), 8'h55);

    do_hit(10'd170, 10'd130);
    check("overlap_ready", {31'd0, hit_ready}, 1);
    probe("overlap_b1", 10'd180, 10'd137, 1'b1, 1'b0, phase_exp(), 8'hDC);

    do_hit(10'd305, 10'd205);
    check("b2_bump", {31'd0, hit_ready}, 0);
    pulse_tick();
    pulse_tick();
    room_active = 1'b0;
    step();
    check("inactive_ready", {31'd0, hit_ready}, 0);
    check("inactive_coin", {31'd0, coin_req}, 0);
    probe("inactive_render", 10'd305, 10'd205, 1'b0, 1'b0, 1'b0, 8'h00);
    room_active = 1'b1;
    step();
    check("reactive_ready", {31'd0, hit_ready}, 1);
    for (int k = 0; k < 10; k++) begin
      pulse_tick();
      check("no_coin_after_drop", {31'd0, coin_req}, 0);
    end
    probe("b2_used", 10'd305, 10'd205, 1'b1, 1'b1, 1'b0, 8'h55);

    while ((m_ticks % 16) != 0) pulse_tick();
    probe("flash_lo_b3", 10'd8, 10'd10, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) pulse_tick();
    probe("flash_hi_b3", 10'd8, 10'd10, 1'b1, 1'b0, 1'b1, 8'h00);
    probe("flash_hi_b0", 10'd160, 10'd120, 1'b1, 1'b1, 1'b0, 8'h00);

    do_hit(10'd8, 10'd10);
    for (int k = 0; k < 8; k++) pulse_tick();
    check("sat_coin_req", {31'd0, coin_req}, 1);
    check("sat_coin_x", {22'd0, coin_x}, 8);
    check("sat_coin_y", {22'd0, coin_y}, 0);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    check("sat_ack", {31'd0, coin_req}, 0);

    do_hit(10'd180, 10'd137);
    pulse_tick(); pulse_tick(); pulse_tick();
    DrawX = 10'd165;
    DrawY = 10'd123;
    step();
    Reset = 1'b0;
    step();
    m_ticks = 0;
    check("midbump_rst_ready", {31'd0, hit_ready}, 0);
    check("midbump_rst_coin", {11'd0, coin_req, coin_x, coin_y}, 0);
    check("midbump_rst_render", {21'd0, is_question, empty_question, question_address}, 0);
    Reset = 1'b1;
    step();
    check("post_rst_ready", {31'd0, hit_ready}, 1);
    probe("post_rst_b0", 10'd165, 10'd123, 1'b1, 1'b0, 1'b0, 8'h35);
    probe("post_rst_b1", 10'd180, 10'd137, 1'b1, 1'b0, 1'b0, 8'hDC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
